// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single-outstanding memory port.
// Define MEM_ARB_FAIR_EN to add a fetch starvation counter; default is strict data priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req_v,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic        if_gnt,
    output logic        if_rsp_v,
    output logic [31:0] if_rdata,

    input  logic        d_req_v,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rsp_v,
    output logic [31:0] d_rdata,

    output logic        m_req_v,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_ready,
    input  logic        m_rsp_v,
    input  logic [31:0] m_rdata
);

    if (STARVE_MAX < 1) begin : g_starve_check
        $error("STARVE_MAX must be at least 1");
    end

    state_t state, state_next;
    logic   kill_q, kill_next;
    logic   sel_i;

`ifdef MEM_ARB_FAIR_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));
    assign sel_i   = if_req_v && (!d_req_v || starved);

    // Counts data wins over a waiting fetch; saturates so fetch keeps priority until served.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && if_req_v && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign sel_i = if_req_v && !d_req_v;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            kill_q <= 1'b0;
        end else begin
            state  <= state_next;
            kill_q <= kill_next;
        end
    end

    always_comb begin
        state_next = state;
        kill_next  = kill_q;
        m_req_v    = 1'b0;
        m_we       = 1'b0;
        m_addr     = if_addr;
        m_wdata    = '0;
        m_be       = 4'hF;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_rsp_v   = 1'b0;
        d_rsp_v    = 1'b0;
        if_rdata   = m_rdata;
        d_rdata    = m_rdata;

        if (!sel_i) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_be    = d_be;
        end

        if (!reset) begin
            unique case (state)
                IDLE: begin
                    m_req_v = if_req_v | d_req_v;
                    if_gnt  = m_req_v & m_ready & sel_i;
                    d_gnt   = m_req_v & m_ready & ~sel_i;
                    if (if_gnt) begin
                        state_next = BUSY_I;
                        kill_next  = if_kill;
                    end else if (d_gnt) begin
                        state_next = BUSY_D;
                    end
                end
                BUSY_I: begin
                    // A kill arriving alongside the response still discards it.
                    if_rsp_v = m_rsp_v & ~kill_q & ~if_kill;
                    if (m_rsp_v) begin
                        state_next = IDLE;
                        kill_next  = 1'b0;
                    end else if (if_kill) begin
                        kill_next = 1'b1;
                    end
                end
                BUSY_D: begin
                    d_rsp_v = m_rsp_v;
                    if (m_rsp_v) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    kill_next  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then randomized traffic vs. a reference model.
module tb_mem_arbiter;
    localparam int SMAX = 4;

    typedef struct packed {
        logic        rst, ifv, ik, dv, dwe;
        logic [31:0] ia, da, dwd;
        logic [3:0]  dbe;
        logic        mr, mrv;
        logic [31:0] mrd;
    } stim_t;

    typedef struct packed {
        logic        mreq, ig, dg, irsp, drsp, mwe;
        logic [31:0] maddr, mwdata;
        logic [3:0]  mbe;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req_v = 1'b0, if_kill = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rsp_v;
    logic [31:0] if_rdata;
    logic        d_req_v = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        d_gnt, d_rsp_v;
    logic [31:0] d_rdata;
    logic        m_req_v, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_ready = 1'b0, m_rsp_v = 1'b0;
    logic [31:0] m_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req_v(if_req_v), .if_addr(if_addr), .if_kill(if_kill),
        .if_gnt(if_gnt), .if_rsp_v(if_rsp_v), .if_rdata(if_rdata),
        .d_req_v(d_req_v), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rsp_v(d_rsp_v), .d_rdata(d_rdata),
        .m_req_v(m_req_v), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ready(m_ready), .m_rsp_v(m_rsp_v), .m_rdata(m_rdata)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: who owns the memory port (0 none, 1 fetch, 2 data), kill, starvation.
    int   busy = 0;
    bit   killed = 1'b0;
    int   starve = 0;

    bit   logging = 1'b0;
    byte  gnt_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        bit   pick_i;
        bit   fair;
        fair = 1'b0;
`ifdef MEM_ARB_FAIR_EN
        fair = 1'b1;
`endif
        @(posedge clk);
        #1;
        reset    = s.rst;
        if_req_v = s.ifv;
        if_addr  = s.ia;
        if_kill  = s.ik;
        d_req_v  = s.dv;
        d_we     = s.dwe;
        d_addr   = s.da;
        d_wdata  = s.dwd;
        d_be     = s.dbe;
        m_ready  = s.mr;
        m_rsp_v  = s.mrv;
        m_rdata  = s.mrd;

        e = '0;
        e.mreq = !s.rst && busy == 0 && (s.ifv || s.dv);
        pick_i = s.ifv && (!s.dv || (fair && starve >= SMAX));
        e.ig   = e.mreq && s.mr && pick_i;
        e.dg   = e.mreq && s.mr && !pick_i;
        if (pick_i) begin
            e.mwe = 1'b0; e.maddr = s.ia; e.mwdata = '0; e.mbe = 4'hF;
        end else begin
            e.mwe = s.dwe; e.maddr = s.da; e.mwdata = s.dwd; e.mbe = s.dbe;
        end
        e.irsp  = !s.rst && busy == 1 && s.mrv && !killed && !s.ik;
        e.drsp  = !s.rst && busy == 2 && s.mrv;
        e.rdata = s.mrd;
        exp_q.push_back(e);

        if (s.rst) begin
            busy = 0; killed = 1'b0; starve = 0;
        end else if (busy == 0) begin
            if (e.ig) begin
                busy = 1; killed = s.ik; starve = 0;
            end else if (e.dg) begin
                busy = 2;
                if (s.ifv && starve < SMAX) starve++;
            end
        end else begin
            if (busy == 1 && s.ik) killed = 1'b1;
            if (s.mrv) begin
                busy = 0; killed = 1'b0;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (logging) begin
                if (if_gnt) gnt_log.push_back(8'h49);
                if (d_gnt)  gnt_log.push_back(8'h44);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("m_req_v",  32'(m_req_v),  32'(e.mreq));
                check("if_gnt",   32'(if_gnt),   32'(e.ig));
                check("d_gnt",    32'(d_gnt),    32'(e.dg));
                check("if_rsp_v", 32'(if_rsp_v), 32'(e.irsp));
                check("d_rsp_v",  32'(d_rsp_v),  32'(e.drsp));
                if (e.mreq) begin
                    check("m_we",    32'(m_we),    32'(e.mwe));
                    check("m_addr",  m_addr,       e.maddr);
                    check("m_wdata", m_wdata,      e.mwdata);
                    check("m_be",    32'(m_be),    32'(e.mbe));
                end
                if (e.irsp) check("if_rdata", if_rdata, e.rdata);
                if (e.drsp) check("d_rdata",  d_rdata,  e.rdata);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        byte   exp_pat[$];

        // Reset
        s = '0; s.rst = 1'b1;
        step(s); step(s);

        // Single fetch, response two cycles after grant
        s = '0; s.ifv = 1'b1; s.ia = 32'h100; s.mr = 1'b1; step(s);
        s = '0; step(s);
        s = '0; s.mrv = 1'b1; s.mrd = 32'h0000_0013; step(s);

        // Collision: data write wins, fetch follows in next IDLE
        s = '0; s.ifv = 1'b1; s.ia = 32'h140; s.dv = 1'b1; s.dwe = 1'b1;
        s.da = 32'h2000; s.dwd = 32'hA5A5_0F0F; s.dbe = 4'h3; s.mr = 1'b1; step(s);
        s = '0; s.ifv = 1'b1; s.ia = 32'h140; s.mrv = 1'b1; s.mrd = 32'hDEAD_BEEF; step(s);
        s = '0; s.ifv = 1'b1; s.ia = 32'h140; s.mr = 1'b1; step(s);
        s = '0; s.mrv = 1'b1; s.mrd = 32'h1234_5678; step(s);

        // Backpressure
        s = '0; s.ifv = 1'b1; s.ia = 32'h200;
        repeat (5) step(s);
        s.mr = 1'b1; step(s);
        s = '0; s.mrv = 1'b1; s.mrd = 32'h0BAD_F00D; step(s);

        // Kill in BUSY_I, then a clean fetch
        s = '0; s.ifv = 1'b1; s.ia = 32'h300; s.mr = 1'b1; step(s);
        s = '0; s.ik = 1'b1; step(s);
        s = '0; s.mrv = 1'b1; s.mrd = 32'h0000_0BAD; step(s);
        s = '0; s.ifv = 1'b1; s.ia = 32'h304; s.mr = 1'b1; step(s);
        s = '0; s.mrv = 1'b1; s.mrd = 32'h0000_600D; step(s);

        // Kill in the handshake cycle
        s = '0; s.ifv = 1'b1; s.ia = 32'h308; s.mr = 1'b1; s.ik = 1'b1; step(s);
        s = '0; s.mrv = 1'b1; s.mrd = 32'h0000_0001; step(s);

        // Reset abandons a data read; stale response in IDLE is ignored
        s = '0; s.dv = 1'b1; s.da = 32'h4000; s.dbe = 4'hF; s.mr = 1'b1; step(s);
        s = '0; s.rst = 1'b1; step(s);
        s = '0; s.mrv = 1'b1; s.mrd = 32'h5555_AAAA; step(s);

        // Starvation: both held, one-cycle memory latency
        s = '0; s.rst = 1'b1; step(s);
        logging = 1'b1;
        s = '0; s.ifv = 1'b1; s.ia = 32'h500; s.dv = 1'b1; s.da = 32'h6000;
        s.dbe = 4'hF; s.mr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s.mrv = (i % 2 == 1);
            s.mrd = 32'(i);
            step(s);
        end
        @(negedge clk);
        #1;
        logging = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s = '0;
            s.rst = ($urandom_range(0, 63) == 0);
            s.ifv = ($urandom_range(0, 1) == 1);
            s.ia  = $urandom;
            s.ik  = ($urandom_range(0, 5) == 0);
            s.dv  = ($urandom_range(0, 3) != 0);
            s.dwe = ($urandom_range(0, 1) == 1);
            s.da  = $urandom;
            s.dwd = $urandom;
            s.dbe = 4'($urandom_range(0, 15));
            s.mr  = ($urandom_range(0, 3) != 0);
            s.mrv = (busy != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            s.mrd = $urandom;
            step(s);
        end
        @(negedge clk);
        #1;

        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

`ifdef MEM_ARB_FAIR_EN
        exp_pat = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h49, 8'h44};
`else
        exp_pat = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44};
`endif
        check("starve_grant_count", 32'(gnt_log.size()), 32'(exp_pat.size()));
        for (int i = 0; i < exp_pat.size(); i++) begin
            check("starve_grant_order",
                  (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'd0, 32'(exp_pat[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
